pipelined_group_carry_adder: RTL
================================

// Module: pipelined_group_carry_adder
// PURPOSE
//  Two-stage pipelined WIDTH-bit adder/subtractor for the KGP RISC ALU datapath.
//  - Stage 1: instantiates WIDTH/4 four-bit CLA slices and registers each nibble's
//    group propagate P and group generate G, together with the operands.
//  - Stage 2: resolves the nibble carries with a second-level lookahead unit,
//    then forms the sum and the flags.
//  - Sits between the register-read stage and ALU writeback; valid/ready on both sides.
// PARAMETERS
//  WIDTH   32   operand width; multiple of 4, range 8..64
//  NGRP    WIDTH/4   nibble group count; localparam, never overridden
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      stage 1 can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in; ignored when in_sub=1
//  in_sub     in   1      1: A - B, computed as A + ~B + 1
//  out_valid  out  1      result beat held
//  out_ready  in   1      downstream accepts this cycle
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of MSB; for sub, 1 = no borrow
//  out_ovf    out  1      signed overflow = carry(MSB) ^ carry(into MSB)
//  out_zero   out  1      out_sum == 0
//  out_neg    out  1      out_sum[WIDTH-1]
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): s1_valid=0, s2_valid=0; all output registers 0.
//    Reset has priority over any handshake and discards in-flight beats.
//    in_ready is 0 while rst_n=0.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  - Stage advance: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv;
//    in_ready = rst_n & s1_adv (combinational, no in_valid dependence).
//  - Stage 1 register loads when s1_adv:
//    b_eff = in_sub ? ~in_b : in_b; c0 = in_sub | in_cin;
//    captures a, b_eff, c0, P[NGRP], G[NGRP].
//    P/G use the slice definitions: p_i = a_i|b_i, g_i = a_i&b_i.
//  - Stage 2 register loads when s2_adv:
//    C[0] = c0; C[k+1] = G[k] | P[k]&C[k], flattened by the lookahead unit.
//    sum = a ^ b_eff ^ bitcarry; bit carries inside a nibble are recomputed
//    from C[k].
//  - Latency: exactly 2 cycles from input transfer to out_valid, out_ready held 1.
//  - Throughput: 1 beat/cycle; no bubbles while out_ready=1.
//  - Backpressure: out_ready=0 with both stages full drops in_ready the same cycle.
//    Held outputs stay stable until transferred.
//  - Simultaneous in-transfer and out-transfer with both stages full: both
//    stages shift; no beat is lost or duplicated.
//  - Beats leave in order. No combinational path from in_* to out_*.
//  - Arithmetic is modulo 2^WIDTH.
//    out_cout and out_ovf are both valid for add and sub.
// STRUCTURE
//  - Shared package alu_pkg: ALU_WIDTH=32, NIBBLE=4, and a typedef for the
//    {sum,cout,ovf,zero,neg} result struct shared with the ALU writeback stage.
//  - Sub-module block_carry_lookahead_unit #(NGRP):
//    inputs P[NGRP], G[NGRP], c0; outputs C[NGRP:0];
//    combinational, two-level: groups of 4, then across groups.
//  - Nibble P/G come from the existing 4-bit CLA slices, generate-instanced.
// TESTING
//  1. Add, WIDTH=32: 0x0000_0001 + 0xFFFF_FFFF, cin=0 -> 2 cycles later
//     sum=0, cout=1, zero=1, ovf=0.
//  2. Add: 0x7FFF_FFFF + 1 -> sum=0x8000_0000, ovf=1, neg=1, cout=0.
//  3. Sub: 5 - 7 -> sum=0xFFFF_FFFE, cout=0, neg=1.
//     Sub: 7 - 5 -> sum=2, cout=1.
//  4. Stream 8 beats back-to-back, out_ready=1 -> 8 results on consecutive cycles.
//     Check in order against a reference model.
//  5. Hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 after 2 accepts.
//     Outputs stay stable; release -> remaining beats drain in order, no loss.
//  6. rst_n=0 for 1 cycle with both stages full -> out_valid=0 and outputs 0
//     next cycle; in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and the result record handed to ALU writeback.
//   ALU_WIDTH    : default datapath width
//   NIBBLE       : carry-lookahead slice width
//   alu_result_t : {sum, cout, ovf, zero, neg}
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned NIBBLE    = 4;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] sum;
    logic                 cout;
    logic                 ovf;
    logic                 zero;
    logic                 neg;
  } alu_result_t;

endpackage

// File: rtl/pipelined_group_carry_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
//   master : operand producer and result consumer (register-read / writeback side)
//   slave  : the adder itself
interface pipelined_group_carry_adder_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );

endinterface

// File: rtl/block_carry_lookahead_unit.sv
// Second-level lookahead: resolves every nibble carry from nibble P/G and c0.
//   p, g : per-nibble group propagate/generate
//   c0   : carry into nibble 0
//   c    : c[k] = carry into nibble k, c[NGRP] = carry out of the MSB
// Nibbles are combined four at a time into super-groups; super-group carries
// are resolved first, then the carries inside each super-group.
module block_carry_lookahead_unit #(
  parameter int unsigned NGRP = 8
) (
  input  logic [NGRP-1:0] p,
  input  logic [NGRP-1:0] g,
  input  logic            c0,
  output logic [NGRP:0]   c
);

  localparam int unsigned NSUP = (NGRP + 3) / 4;
  localparam int unsigned NPAD = NSUP * 4;

  logic [NPAD-1:0] pp;
  logic [NPAD-1:0] gp;
  logic [NSUP-1:0] sp;
  logic [NSUP-1:0] sg;
  logic [NSUP:0]   sc;
  logic [NPAD:0]   cp;
  logic            cin;

  // Padding nibbles propagate and never generate, so they leave P/G untouched.
  always_comb begin
    pp = '1;
    gp = '0;
    pp[NGRP-1:0] = p;
    gp[NGRP-1:0] = g;
  end

  always_comb begin
    sp  = '1;
    sg  = '0;
    sc  = '0;
    cp  = '0;
    cin = 1'b0;
    for (int s = 0; s < int'(NSUP); s++) begin
      for (int j = 0; j < 4; j++) begin
        sg[s] = gp[s*4+j] | (pp[s*4+j] & sg[s]);
        sp[s] = sp[s] & pp[s*4+j];
      end
    end
    sc[0] = c0;
    for (int s = 0; s < int'(NSUP); s++) begin
      sc[s+1] = sg[s] | (sp[s] & sc[s]);
    end
    cp[0] = c0;
    for (int k = 0; k < int'(NPAD); k++) begin
      cin = (k % 4 == 0) ? sc[k/4] : cp[k];
      // The last nibble of a super-group takes its carry-out from the upper level.
      if (k % 4 == 3) begin
        cp[k+1] = sc[k/4+1];
      end else begin
        cp[k+1] = gp[k] | (pp[k] & cin);
      end
    end
  end

  assign c = cp[NGRP:0];

endmodule

// File: rtl/cla4_slice.sv
// Four-bit carry-lookahead slice: group propagate and group generate of one nibble.
//   a, b   : nibble operands
//   p_grp  : all four bits propagate (p_i = a_i | b_i)
//   g_grp  : nibble generates a carry out on its own (g_i = a_i & b_i)
module cla4_slice
  import alu_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  output logic              p_grp,
  output logic              g_grp
);

  logic [NIBBLE-1:0] p;
  logic [NIBBLE-1:0] g;

  assign p     = a | b;
  assign g     = a & b;
  assign p_grp = &p;
  assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipelined_group_carry_adder.sv
// Two-stage pipelined adder/subtractor for the ALU datapath.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of the operand/result handshake
//                in_*  : operands, carry-in, subtract select, valid/ready
//                out_* : sum, carry out, signed overflow, zero, negative, valid/ready
// Stage 1 registers the operands (B already inverted for subtract) and the
// nibble P/G; stage 2 resolves carries and registers sum and flags.
module pipelined_group_carry_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipelined_group_carry_adder_if.slave  bus
);

  localparam int unsigned NGRP = WIDTH / NIBBLE;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [NGRP-1:0]  p_in;
  logic [NGRP-1:0]  g_in;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_c0;
  logic [NGRP-1:0]  s1_p;
  logic [NGRP-1:0]  s1_g;

  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] sum_c;
  logic             c_run;

  logic             s1_adv;
  logic             s2_adv;

  // Subtract is A + ~B + 1; carry-in is ignored in that case.
  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0    = bus.in_sub | bus.in_cin;

  for (genvar k = 0; k < int'(NGRP); k++) begin : g_slice
    cla4_slice u_slice (
      .a     (bus.in_a[k*NIBBLE +: NIBBLE]),
      .b     (b_eff[k*NIBBLE +: NIBBLE]),
      .p_grp (p_in[k]),
      .g_grp (g_in[k])
    );
  end

  assign s2_adv       = !bus.out_valid | bus.out_ready;
  assign s1_adv       = !s1_valid | s2_adv;
  assign bus.in_ready = rst_n & s1_adv;

  // Stage 1: operand and nibble P/G capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c0    <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      s1_a     <= bus.in_a;
      s1_b     <= b_eff;
      s1_c0    <= c0;
      s1_p     <= p_in;
      s1_g     <= g_in;
    end
  end

  block_carry_lookahead_unit #(
    .NGRP (NGRP)
  ) u_bclu (
    .p  (s1_p),
    .g  (s1_g),
    .c0 (s1_c0),
    .c  (grp_c)
  );

  // Bit carries inside each nibble, seeded by that nibble's resolved carry.
  always_comb begin
    bit_c = '0;
    c_run = 1'b0;
    for (int k = 0; k < int'(NGRP); k++) begin
      c_run = grp_c[k];
      for (int j = 0; j < int'(NIBBLE); j++) begin
        bit_c[k*NIBBLE+j] = c_run;
        c_run = (s1_a[k*NIBBLE+j] & s1_b[k*NIBBLE+j]) |
                ((s1_a[k*NIBBLE+j] | s1_b[k*NIBBLE+j]) & c_run);
      end
    end
    sum_c = s1_a ^ s1_b ^ bit_c;
  end

  // Stage 2: result and flag registers, held until the downstream takes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_cout  <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_zero  <= 1'b0;
      bus.out_neg   <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      bus.out_sum   <= sum_c;
      bus.out_cout  <= grp_c[NGRP];
      bus.out_ovf   <= grp_c[NGRP] ^ bit_c[WIDTH-1];
      bus.out_zero  <= (sum_c == '0);
      bus.out_neg   <= sum_c[WIDTH-1];
    end
  end

endmodule
